// File: rtl/div_issue_unit.sv
// Issue/result sequencer around the combinational 32/16 divider: holds the
// operands through a settle window, then samples and sign-corrects the quotient.
module div_issue_unit #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [15:0] data_operandB,
    output logic [31:0] div_operandA,
    output logic [15:0] div_operandB,
    input  logic [31:0] div_result,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_inputRDY,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // The counter is loaded with SETTLE_CYCLES-1 so the sample lands exactly
    // SETTLE_CYCLES edges after the accept edge.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 32'd1);

    function automatic logic [31:0] sign_fix(input logic neg, input logic [31:0] mag);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic [31:0] r_op_a;
    logic [31:0] w_op_a_nxt;
    logic [15:0] r_op_b;
    logic [15:0] w_op_b_nxt;
    logic        r_sign;
    logic        w_sign_nxt;
    logic [31:0] r_result;
    logic [31:0] w_result_nxt;
    logic        r_exc;
    logic        w_exc_nxt;
    logic        r_input_rdy;
    logic        w_input_rdy_nxt;
    logic        r_result_rdy;
    logic        w_result_rdy_nxt;
    logic        w_accept;

    // Next-state and next-register computation for the issue sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_op_a_nxt   = r_op_a;
        w_op_b_nxt   = r_op_b;
        w_sign_nxt   = r_sign;
        w_result_nxt = r_result;
        w_exc_nxt    = r_exc;
        w_accept     = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (ctrl_DIV) begin
                    w_accept = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_count == 4'd0) begin
                    w_result_nxt = sign_fix(r_sign, div_result);
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_count_nxt = r_count - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Divide-by-zero never waits for the divider; it completes on the accept edge.
        if (w_accept) begin
            w_op_a_nxt = data_operandA;
            w_op_b_nxt = data_operandB;
            w_sign_nxt = data_operandA[31] ^ data_operandB[15];
            w_exc_nxt  = 1'b0;
            if (data_operandB == 16'd0) begin
                w_exc_nxt    = 1'b1;
                w_result_nxt = 32'd0;
                w_state_nxt  = ST_DONE;
            end else begin
                w_count_nxt = SETTLE_LOAD;
                w_state_nxt = ST_SETTLE;
            end
        end else begin
            w_sign_nxt = w_sign_nxt;
        end

        w_input_rdy_nxt  = (w_state_nxt != ST_SETTLE);
        w_result_rdy_nxt = (w_state_nxt == ST_DONE);
    end

    // State, operand, result and handshake registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_count      <= 4'd0;
            r_op_a       <= 32'd0;
            r_op_b       <= 16'd0;
            r_sign       <= 1'b0;
            r_result     <= 32'd0;
            r_exc        <= 1'b0;
            r_input_rdy  <= 1'b1;
            r_result_rdy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_op_a       <= w_op_a_nxt;
            r_op_b       <= w_op_b_nxt;
            r_sign       <= w_sign_nxt;
            r_result     <= w_result_nxt;
            r_exc        <= w_exc_nxt;
            r_input_rdy  <= w_input_rdy_nxt;
            r_result_rdy <= w_result_rdy_nxt;
        end
    end

    assign div_operandA   = r_op_a;
    assign div_operandB   = r_op_b;
    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_inputRDY  = r_input_rdy;
    assign data_resultRDY = r_result_rdy;

endmodule

// File: tb/tb_div_issue_unit.sv
// Self-checking bench for div_issue_unit: directed vector table, hand-written
// corner sequences, and randomized traffic against an event-time reference model.
module tb_div_issue_unit;

    localparam int SC = 4;

    logic        clock;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [15:0] data_operandB;
    logic [31:0] div_operandA;
    logic [15:0] div_operandB;
    logic [31:0] div_result;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_inputRDY;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model: an accepted op is "due" at a known edge number.
    logic [31:0] m_a;
    logic [15:0] m_b;
    logic [31:0] m_res;
    logic        m_exc;
    logic        m_pulse;
    int          m_due;

    div_issue_unit #(.SETTLE_CYCLES(SC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .div_operandA   (div_operandA),
        .div_operandB   (div_operandB),
        .div_result     (div_result),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_inputRDY  (data_inputRDY),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic longint abs_l(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Behavioural combinational divider: unsigned magnitude |A|/|B|.
    function automatic logic [31:0] divider(input logic [31:0] a, input logic [15:0] b);
        longint q;
        if (b == 16'd0) return 32'hFFFF_FFFF;
        q = abs_l(longint'($signed(a))) / abs_l(longint'($signed(b)));
        return q[31:0];
    endfunction

    // Expected signed quotient, truncated to 32 bits.
    function automatic logic [31:0] signed_quot(input logic [31:0] a, input logic [15:0] b);
        longint sa;
        longint sb;
        longint q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = abs_l(sa) / abs_l(sb);
        if ((sa < 0) != (sb < 0)) q = -q;
        return q[31:0];
    endfunction

    assign div_result = divider(div_operandA, div_operandB);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_a = 32'd0; m_b = 16'd0; m_res = 32'd0; m_exc = 1'b0;
            m_pulse = 1'b0; m_due = -1;
        end else begin
            m_pulse = 1'b0;
            if (m_due == edge_no) begin
                m_res   = signed_quot(m_a, m_b);
                m_pulse = 1'b1;
                m_due   = -1;
            end else if (m_due < 0 && ctrl_DIV) begin
                m_a   = data_operandA;
                m_b   = data_operandB;
                m_exc = 1'b0;
                if (data_operandB == 16'd0) begin
                    m_exc   = 1'b1;
                    m_res   = 32'd0;
                    m_pulse = 1'b1;
                end else begin
                    m_due = edge_no + SC;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("div_operandA", div_operandA, m_a);
        check("div_operandB", {16'd0, div_operandB}, {16'd0, m_b});
        check("data_result", data_result, m_res);
        check("data_exception", {31'd0, data_exception}, {31'd0, m_exc});
        check("data_inputRDY", {31'd0, data_inputRDY}, {31'd0, (m_due < 0)});
        check("data_resultRDY", {31'd0, data_resultRDY}, {31'd0, m_pulse});
    endtask

    // One clock edge: advance the model with pre-edge inputs, then compare.
    task automatic tick();
        @(posedge clock);
        edge_no++;
        model_step();
        #1;
        compare_all();
    endtask

    // Issue one op, then count edges until the result pulse.
    task automatic run_op(input string name, input logic [31:0] a, input logic [15:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        int exp_lat;
        ctrl_DIV = 1'b1; data_operandA = a; data_operandB = b;
        tick();
        ctrl_DIV = 1'b0;
        lat = 0;
        while (!data_resultRDY && lat < 30) begin
            tick();
            lat++;
        end
        exp_lat = (b == 16'd0) ? 0 : SC;
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, data_result, exp_res);
        check({name, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
    endtask

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int e1;
        int pulses;
        int lat;

        tbl[0] = '{32'd100,                16'd7,        32'd14,          1'b0};
        tbl[1] = '{-32'sd100,              16'd7,        32'hFFFF_FFF2,   1'b0};
        tbl[2] = '{32'd100,                -16'sd7,      32'hFFFF_FFF2,   1'b0};
        tbl[3] = '{-32'sd100,              -16'sd7,      32'd14,          1'b0};
        tbl[4] = '{-32'sd3,                16'd7,        32'd0,           1'b0};
        tbl[5] = '{32'd5,                  16'd0,        32'd0,           1'b1};
        tbl[6] = '{32'd8,                  16'd2,        32'd4,           1'b0};
        tbl[7] = '{32'h8000_0000,          16'hFFFF,     32'h8000_0000,   1'b0};
        tbl[8] = '{32'h7FFF_FFFF,          16'h8000,     32'hFFFF_0001,   1'b0};

        reset_n = 1'b0; ctrl_DIV = 1'b0; data_operandA = 32'd0; data_operandB = 16'd0;
        m_due = -1; m_a = 32'd0; m_b = 16'd0; m_res = 32'd0; m_exc = 1'b0; m_pulse = 1'b0;
        tick();
        tick();
        check("reset inputRDY", {31'd0, data_inputRDY}, 32'd1);
        check("reset result", data_result, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc);
        end
        tick();

        // A start request during SETTLE must be ignored.
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 16'd7;
        tick();
        data_operandA = 32'd9; data_operandB = 16'd3;
        lat = 0;
        while (!data_resultRDY && lat < 30) begin
            check("ignore inputRDY low", {31'd0, data_inputRDY}, 32'd0);
            check("ignore opA held", div_operandA, 32'd100);
            tick();
            lat++;
        end
        ctrl_DIV = 1'b0;
        check("ignore result", data_result, 32'd14);
        check("ignore latency", lat, SC);
        tick();

        // Reset in the middle of an in-flight op discards it.
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 16'd7;
        tick();
        ctrl_DIV = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst opA", div_operandA, 32'd0);
        check("rst inputRDY", {31'd0, data_inputRDY}, 32'd1);
        check("rst resultRDY", {31'd0, data_resultRDY}, 32'd0);
        pulses = 0;
        for (int i = 0; i < SC + 2; i++) begin
            tick();
            if (data_resultRDY) pulses++;
        end
        check("rst no pulse", pulses, 0);
        run_op("overflow", 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 1'b0);
        tick();

        // Back-to-back issue with ctrl_DIV held high.
        ctrl_DIV = 1'b1; data_operandA = 32'd20; data_operandB = 16'd4;
        tick();
        data_operandA = 32'd21; data_operandB = 16'd3;
        lat = 0;
        while (!data_resultRDY && lat < 30) begin tick(); lat++; end
        e1 = edge_no;
        check("b2b first result", data_result, 32'd5);
        check("b2b inputRDY in DONE", {31'd0, data_inputRDY}, 32'd1);
        tick();
        ctrl_DIV = 1'b0;
        lat = 0;
        while (!data_resultRDY && lat < 30) begin tick(); lat++; end
        check("b2b second result", data_result, 32'd7);
        check("b2b period", edge_no - e1, SC + 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset_n  = ($urandom_range(0, 99) != 0);
            ctrl_DIV = ($urandom_range(0, 2) == 0);
            data_operandA = $urandom;
            case ($urandom_range(0, 3))
                0:       data_operandB = 16'd0;
                1:       data_operandB = 16'($urandom_range(0, 20)) - 16'd10;
                2:       data_operandB = 16'($urandom);
                default: data_operandB = 16'hFFFF;
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
